// File: rtl/and_arb_pkg.sv
// Shared types and the round-robin pick helper for the AND-datapath arbiter.
package and_arb_pkg;

    localparam int unsigned MAX_REQ = 16;
    localparam int unsigned MAX_IDW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic               found;
        logic [MAX_IDW-1:0] idx;
    } rr_pick_t;

    // Scans ptr, ptr+1, ... mod n_req and returns the first requesting index.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0] req,
        input logic [MAX_IDW-1:0] ptr,
        input int unsigned        n_req
    );
        rr_pick_t           res;
        logic [MAX_IDW-1:0] idx;
        int unsigned        pos;
        res = '0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            pos = (32'(ptr) + k) % n_req;
            idx = pos[MAX_IDW-1:0];
            if (k < n_req && !res.found && req[idx]) begin
                res.found = 1'b1;
                res.idx   = idx;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/and_datapath.sv
// Combinational WIDTH-bit bitwise AND unit shared by all requesters.
module and_datapath #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    assign y = a & b;

endmodule

// File: rtl/and_arbiter_ctrl.sv
// Round-robin arbiter time-multiplexing one registered AND datapath among
// N_REQ requesters, with a single valid/ready tagged response port.
module and_arbiter_ctrl #(
    parameter  int unsigned N_REQ = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [WIDTH-1:0]       rsp_data,
    output logic [IDW-1:0]         rsp_id,
    output logic                   busy
);

    import and_arb_pkg::*;

    state_t               state;
    logic [IDW-1:0]       ptr;
    logic [IDW-1:0]       lat_id;
    logic [WIDTH-1:0]     lat_a;
    logic [WIDTH-1:0]     lat_b;
    logic [WIDTH-1:0]     dp_y;
    logic [MAX_REQ-1:0]   req_pad;
    logic [MAX_IDW-1:0]   ptr_pad;
    rr_pick_t             pick;
    logic [IDW-1:0]       win;
    logic                 xfer;
    logic [WIDTH-1:0]     a_arr [N_REQ];
    logic [WIDTH-1:0]     b_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign a_arr[i] = a_in[i*WIDTH +: WIDTH];
        assign b_arr[i] = b_in[i*WIDTH +: WIDTH];
    end

    // Grant is combinational from req so a request can transfer in its first IDLE cycle.
    always_comb begin
        req_pad              = '0;
        req_pad[N_REQ-1:0]   = req;
        ptr_pad              = '0;
        ptr_pad[IDW-1:0]     = ptr;
        pick                 = rr_pick(req_pad, ptr_pad, N_REQ);
        win                  = IDW'(pick.idx);
        gnt                  = '0;
        if (state == IDLE && !rst && pick.found) begin
            gnt[win] = 1'b1;
        end
        xfer = |(req & gnt);
    end

    and_datapath #(.WIDTH(WIDTH)) u_datapath (
        .a (lat_a),
        .b (lat_b),
        .y (dp_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            lat_id    <= '0;
            lat_a     <= '0;
            lat_b     <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        lat_id <= win;
                        lat_a  <= a_arr[win];
                        lat_b  <= b_arr[win];
                        ptr    <= (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= dp_y;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_and_arbiter_ctrl.sv
// Scoreboard bench for and_arbiter_ctrl: directed scenarios plus random traffic.
module tb_and_arbiter_ctrl;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   a_in;
    logic [N*W-1:0]   b_in;
    logic [N-1:0]     gnt;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_data;
    logic [IDW-1:0]   rsp_id;
    logic             busy;

    logic [W-1:0]     opa [N];
    logic [W-1:0]     opb [N];

    always #5 clk = ~clk;

    always_comb begin
        a_in = '0;
        b_in = '0;
        for (int i = 0; i < N; i++) begin
            a_in[i*W +: W] = opa[i];
            b_in[i*W +: W] = opb[i];
        end
    end

    and_arbiter_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .busy      (busy)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        int id;
        int data;
    } exp_t;

    exp_t q[$];
    int   glog[$];
    int   m_ptr   = 0;
    int   m_phase = 0;   // 0 idle, 1 computing, 2 response pending

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int glog_at(input int k);
        return (k < glog.size()) ? glog[k] : -1;
    endfunction

    // Reference model: spec-level round robin and transaction phases.
    always @(negedge clk) begin : model
        logic [N-1:0] eg;
        int           w;
        int           idx;
        if (rst) begin
            check("rst_gnt", 32'(gnt), 32'(0));
            check("rst_busy", 32'(busy), 32'(0));
            check("rst_valid", 32'(rsp_valid), 32'(0));
            m_ptr   = 0;
            m_phase = 0;
            q.delete();
        end else begin
            eg = '0;
            w  = -1;
            if (m_phase == 0) begin
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (w < 0 && ((req >> idx) & 4'b0001) != 4'b0000) w = idx;
                end
            end
            if (w >= 0) eg = N'(1 << w);
            check("gnt", 32'(gnt), 32'(eg));
            check("busy", 32'(busy), 32'(m_phase != 0));
            check("rsp_valid", 32'(rsp_valid), 32'(m_phase == 2));
            case (m_phase)
                0: if (w >= 0) begin
                    q.push_back('{id: w, data: 32'(opa[w] & opb[w])});
                    glog.push_back(w);
                    m_ptr   = (w + 1) % N;
                    m_phase = 1;
                end
                1: m_phase = 2;
                default: if (rsp_ready) m_phase = 0;
            endcase
        end
    end

    // Monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        #1;
        if (!rst && rsp_valid) begin
            if (q.size() == 0) begin
                check("rsp_unexpected", 32'(rsp_valid), 32'(0));
            end else begin
                check("rsp_id", 32'(rsp_id), 32'(q[0].id));
                check("rsp_data", 32'(rsp_data), 32'(q[0].data));
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        req = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (!busy && q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check("drain_timeout", 32'(ok), 32'(1));
    endtask

    task automatic do_reset();
        req = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            opa[i] = W'($urandom);
            opb[i] = W'($urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int           base;
        int           p;
        bit           got;
        logic [N-1:0] g;

        rst = 1'b1;
        req = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        step(2);
        rst = 1'b0;
        check("reset_rsp_data", 32'(rsp_data), 32'(0));
        check("reset_rsp_id", 32'(rsp_id), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_busy", 32'(busy), 32'(0));

        // Single request: latency and earliest next grant
        opa[2] = 8'hF0;
        opb[2] = 8'h3C;
        req = 4'b0100;
        #1 check("t1_gnt", 32'(gnt), 32'(4'b0100));
        step(1);
        check("t1_exec_gnt", 32'(gnt), 32'(0));
        step(1);
        check("t1_valid", 32'(rsp_valid), 32'(1));
        check("t1_data", 32'(rsp_data), 32'(8'h30));
        check("t1_id", 32'(rsp_id), 32'(2));
        check("t1_resp_gnt", 32'(gnt), 32'(0));
        step(1);
        check("t1_next_gnt", 32'(gnt), 32'(4'b0100));
        step(1);
        drain();

        // Contention from reset: order 0,1,2,3,0
        do_reset();
        rand_ops();
        base = glog.size();
        req = 4'b1111;
        step(15);
        drain();
        for (int k = 0; k < 5; k++) check("rr_order", 32'(glog_at(base + k)), 32'(k % N));

        // Fairness: req1 held, req3 raised once
        rand_ops();
        req = 4'b0010;
        step(2);
        base = glog.size();
        req[3] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (gnt[3]) begin
                @(posedge clk);
                #1 req[3] = 1'b0;
                got = 1'b1;
                break;
            end
        end
        check("fair_timeout", 32'(got), 32'(1));
        step(6);
        drain();
        p = (glog_at(base) == 3) ? 0 : ((glog_at(base + 1) == 3) ? 1 : 9);
        check("fair_within_two", 32'(p <= 1), 32'(1));
        check("fair_next_is_1", 32'(glog_at(base + p + 1)), 32'(1));

        // Backpressure: 5+ cycles of rsp_ready low in RESP
        do_reset();
        rand_ops();
        rsp_ready = 1'b0;
        req = 4'b0001;
        step(1);
        req = 4'b1111;
        step(1);
        step(5);
        check("bp_valid_held", 32'(rsp_valid), 32'(1));
        rsp_ready = 1'b1;
        step(1);
        check("bp_idle_busy", 32'(busy), 32'(0));
        check("bp_idle_gnt", 32'(gnt), 32'(4'b0010));
        drain();

        // Withdrawal while busy
        do_reset();
        rand_ops();
        rsp_ready = 1'b1;
        base = glog.size();
        req = 4'b0100;
        step(1);
        req = 4'b0001;
        step(1);
        req = 4'b0000;
        step(3);
        check("wd_one_grant", 32'(glog.size() - base), 32'(1));
        check("wd_grant_id", 32'(glog_at(base)), 32'(2));
        req = 4'b1111;
        #1 check("wd_ptr_kept", 32'(gnt), 32'(4'b1000));
        step(1);
        drain();

        // Asynchronous reset during EXEC
        req = 4'b0010;
        @(posedge clk);
        #3;
        req = 4'b1111;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_busy", 32'(busy), 32'(0));
        check("mid_rst_gnt", 32'(gnt), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        req = 4'b0001;
        #1 check("mid_rst_first_gnt", 32'(gnt), 32'(4'b0001));
        step(1);
        drain();

        // Random traffic honoring the requester contract
        do_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            g = gnt;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && g[i]) begin
                    req[i] = 1'b0;
                end else if (req[i] && $urandom_range(0, 19) == 0) begin
                    req[i] = 1'b0;
                end
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    opa[i] = W'($urandom);
                    opb[i] = W'($urandom);
                    req[i] = 1'b1;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        drain();
        check("final_queue_empty", 32'(q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
